// File: rtl/bp_btb_ras.sv
// Fully-associative BTB with 2-bit direction counters and round-robin allocation.
// Define BP_RAS_EN to add a circular return address stack driven by JAL/JALR predecode.
module bp_btb_ras #(
  parameter int PC_W      = 48,
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lk_valid,
  input  logic [PC_W-1:0] lk_pc,
  input  logic [31:0]     lk_instr,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_pc,
  input  logic            up_valid,
  input  logic [PC_W-1:0] up_pc,
  input  logic [PC_W-1:0] up_target,
  input  logic            up_taken,
  input  logic            flush
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] btb_valid;
  logic [PC_W-1:0]    btb_tag [ENTRIES];
  logic [PC_W-1:0]    btb_tgt [ENTRIES];
  logic [1:0]         btb_ctr [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr;

  logic             lk_hit, up_hit;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [PC_W-1:0]  lk_next_pc;
  logic             ras_use;
  logic [PC_W-1:0]  ras_top;

  assign lk_next_pc = lk_pc + PC_W'(4);

  // Lowest matching index wins for both the lookup and the update port.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    up_hit = 1'b0;
    up_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!lk_hit && btb_valid[i] && (btb_tag[i] == lk_pc)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (!up_hit && btb_valid[i] && (btb_tag[i] == up_pc)) begin
        up_hit = 1'b1;
        up_idx = IDX_W'(i);
      end
    end
  end

`ifdef BP_RAS_EN
  localparam int RAS_W = $clog2(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [RAS_W-1:0] ras_ptr;
  logic [RAS_W:0]   ras_cnt;
  logic [RAS_W-1:0] ras_top_idx;
  logic [6:0]       opcode;
  logic [4:0]       rd, rs1;
  logic [2:0]       funct3;
  logic             rd_link, rs1_link, is_jal, is_jalr;
  logic             ras_push, ras_pop, ras_repl, ras_empty, ras_full;
  logic             unused_instr;

  assign opcode       = lk_instr[6:0];
  assign rd           = lk_instr[11:7];
  assign funct3       = lk_instr[14:12];
  assign rs1          = lk_instr[19:15];
  assign unused_instr = ^lk_instr[31:20];

  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign is_jal   = (opcode == 7'h6f);
  assign is_jalr  = (opcode == 7'h67) && (funct3 == 3'd0);

  assign ras_push = lk_valid && ((is_jal && rd_link) ||
                    (is_jalr && rd_link && (!rs1_link || (rs1 == rd))));
  assign ras_pop  = lk_valid && is_jalr && !rd_link && rs1_link;
  assign ras_repl = lk_valid && is_jalr && rd_link && rs1_link && (rs1 != rd);

  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == (RAS_W+1)'(RAS_DEPTH));
  assign ras_top_idx = ras_ptr - RAS_W'(1);
  assign ras_top     = ras_mem[ras_top_idx];
  assign ras_use     = (ras_pop || ras_repl) && !ras_empty;

  // ras_ptr is the next free slot; a push when full silently drops the oldest entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (flush) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push || (ras_repl && ras_empty)) begin
      ras_mem[ras_ptr] <= lk_next_pc;
      ras_ptr          <= ras_ptr + RAS_W'(1);
      if (!ras_full) ras_cnt <= ras_cnt + (RAS_W+1)'(1);
    end else if (ras_repl) begin
      ras_mem[ras_top_idx] <= lk_next_pc;
    end else if (ras_pop && !ras_empty) begin
      ras_ptr <= ras_top_idx;
      ras_cnt <= ras_cnt - (RAS_W+1)'(1);
    end
  end
`else
  logic unused_ras;
  assign unused_ras = ^{lk_instr, flush};
  assign ras_use    = 1'b0;
  assign ras_top    = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btb_valid <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
        btb_ctr[i] <= '0;
      end
    end else if (up_valid) begin
      if (up_hit) begin
        if (up_taken) begin
          btb_tgt[up_idx] <= up_target;
          if (btb_ctr[up_idx] != 2'd3) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
        end else if (btb_ctr[up_idx] != 2'd0) begin
          btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
        end
      end else if (up_taken) begin
        btb_valid[rr_ptr] <= 1'b1;
        btb_tag[rr_ptr]   <= up_pc;
        btb_tgt[rr_ptr]   <= up_target;
        btb_ctr[rr_ptr]   <= 2'd2;
        rr_ptr            <= rr_ptr + IDX_W'(1);
      end
    end
  end

  // Prediction fields hold their last value across idle lookup cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_hit   <= 1'b0;
      pred_taken <= 1'b0;
      pred_pc    <= '0;
    end else begin
      pred_valid <= lk_valid;
      if (lk_valid) begin
        pred_hit <= lk_hit;
        if (ras_use) begin
          pred_taken <= 1'b1;
          pred_pc    <= ras_top;
        end else if (lk_hit && btb_ctr[lk_idx][1]) begin
          pred_taken <= 1'b1;
          pred_pc    <= btb_tgt[lk_idx];
        end else begin
          pred_taken <= 1'b0;
          pred_pc    <= lk_next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_btb_ras.sv
// Directed and randomized bench for bp_btb_ras against a queue/array reference model.
module tb_bp_btb_ras;
  localparam int PC_W = 48;
  localparam int ENT  = 16;
  localparam int RD   = 8;

  localparam logic [31:0] I_NOP      = 32'h0000_0013;
  localparam logic [31:0] I_JAL_X1   = 32'h0000_00ef;
  localparam logic [31:0] I_RET_X1   = 32'h0000_8067;
  localparam logic [31:0] I_RET_X5   = 32'h0002_8067;
  localparam logic [31:0] I_REPL     = 32'h0002_80e7;
  localparam logic [31:0] I_JALR_X1X1 = 32'h0000_80e7;
  localparam logic [31:0] I_JALR_X5X0 = 32'h0000_02e7;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            lk_valid = 1'b0;
  logic [PC_W-1:0] lk_pc = '0;
  logic [31:0]     lk_instr = '0;
  logic            pred_valid, pred_hit, pred_taken;
  logic [PC_W-1:0] pred_pc;
  logic            up_valid = 1'b0;
  logic [PC_W-1:0] up_pc = '0;
  logic [PC_W-1:0] up_target = '0;
  logic            up_taken = 1'b0;
  logic            flush = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  bp_btb_ras #(.PC_W(PC_W), .ENTRIES(ENT), .RAS_DEPTH(RD)) dut (
    .clk(clk), .reset(reset), .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_instr(lk_instr),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .up_valid(up_valid), .up_pc(up_pc), .up_target(up_target), .up_taken(up_taken),
    .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model
  bit              m_valid [ENT];
  logic [PC_W-1:0] m_tag [ENT];
  logic [PC_W-1:0] m_tgt [ENT];
  int              m_ctr [ENT];
  int              m_rr;
  logic [PC_W-1:0] ras_q [$];
  bit              e_hit, e_taken;
  logic [PC_W-1:0] e_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input logic [PC_W-1:0] pc);
    for (int i = 0; i < ENT; i++) if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  // 0 none, 1 push, 2 pop, 3 replace
  function automatic int ras_kind(input logic [31:0] ins);
    int rd, rs1;
    bit lrd, lrs;
    rd  = int'(ins[11:7]);
    rs1 = int'(ins[19:15]);
    lrd = (rd == 1 || rd == 5);
    lrs = (rs1 == 1 || rs1 == 5);
    if (ins[6:0] == 7'h6f) return lrd ? 1 : 0;
    if (ins[6:0] != 7'h67 || ins[14:12] != 3'd0) return 0;
    if (!lrd && lrs) return 2;
    if (lrd && !lrs) return 1;
    if (lrd && lrs) return (rd == rs1) ? 1 : 3;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    m_rr = 0;
    ras_q.delete();
    e_hit = 0; e_taken = 0; e_pc = '0;
  endtask

  task automatic do_reset();
    lk_valid = 0; up_valid = 0; flush = 0;
    reset = 1;
    #1;
    chk("rst_valid", 64'(pred_valid), 0);
    chk("rst_hit",   64'(pred_hit), 0);
    chk("rst_taken", 64'(pred_taken), 0);
    chk("rst_pc",    64'(pred_pc), 0);
    model_clear();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic step(input bit lkv, input logic [PC_W-1:0] lpc, input logic [31:0] ins,
                      input bit upv, input logic [PC_W-1:0] upc, input logic [PC_W-1:0] utgt,
                      input bit utk, input bit fl);
    int h, k;
    lk_valid = lkv; lk_pc = lpc; lk_instr = ins;
    up_valid = upv; up_pc = upc; up_target = utgt; up_taken = utk; flush = fl;
    k = ras_kind(ins);
    if (lkv) begin
      h = m_find(lpc);
      e_hit = (h >= 0);
      e_taken = 0;
      e_pc = lpc + 48'd4;
      if (h >= 0 && m_ctr[h] >= 2) begin e_taken = 1; e_pc = m_tgt[h]; end
`ifdef BP_RAS_EN
      if ((k == 2 || k == 3) && ras_q.size() > 0) begin e_taken = 1; e_pc = ras_q[$]; end
      if (k == 1 || (k == 3 && ras_q.size() == 0)) begin
        if (ras_q.size() == RD) void'(ras_q.pop_front());
        ras_q.push_back(lpc + 48'd4);
      end else if (k == 3) begin
        ras_q[ras_q.size()-1] = lpc + 48'd4;
      end else if (k == 2 && ras_q.size() > 0) begin
        void'(ras_q.pop_back());
      end
`endif
    end
`ifdef BP_RAS_EN
    if (fl) ras_q.delete();
`endif
    if (upv) begin
      h = m_find(upc);
      if (h >= 0) begin
        if (utk) begin m_tgt[h] = utgt; m_ctr[h] = (m_ctr[h] < 3) ? m_ctr[h] + 1 : 3; end
        else m_ctr[h] = (m_ctr[h] > 0) ? m_ctr[h] - 1 : 0;
      end else if (utk) begin
        m_valid[m_rr] = 1; m_tag[m_rr] = upc; m_tgt[m_rr] = utgt; m_ctr[m_rr] = 2;
        m_rr = (m_rr + 1) % ENT;
      end
    end
    @(posedge clk); #1;
    chk("pred_valid", 64'(pred_valid), 64'(lkv));
    chk("pred_hit",   64'(pred_hit), 64'(e_hit));
    chk("pred_taken", 64'(pred_taken), 64'(e_taken));
    chk("pred_pc",    64'(pred_pc), 64'(e_pc));
  endtask

  task automatic look(input logic [PC_W-1:0] pc, input logic [31:0] ins);
    step(1, pc, ins, 0, '0, '0, 0, 0);
  endtask

  task automatic upd(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt, input bit tk);
    step(0, '0, I_NOP, 1, pc, tgt, tk, 0);
  endtask

  logic [31:0] ins_tab [7];
  logic [PC_W-1:0] rpc, rupc, rtgt;

  initial begin
    ins_tab = '{I_NOP, I_JAL_X1, I_RET_X1, I_RET_X5, I_REPL, I_JALR_X1X1, I_JALR_X5X0};
    #2;
    do_reset();

    look(48'h1000, I_NOP);
    chk("first_hit", 64'(pred_hit), 0);
    chk("first_pc", 64'(pred_pc), 64'h1004);

    upd(48'h1000, 48'h2000, 1);
    look(48'h1000, I_NOP);
    chk("alloc_pc", 64'(pred_pc), 64'h2000);
    upd(48'h1000, 48'h2000, 0);
    upd(48'h1000, 48'h2000, 0);
    look(48'h1000, I_NOP);
    chk("ctr0_pc", 64'(pred_pc), 64'h1004);
    chk("ctr0_hit", 64'(pred_hit), 1);
    for (int i = 0; i < 4; i++) upd(48'h1000, 48'h2400, 1);
    upd(48'h1000, 48'h2400, 0);
    look(48'h1000, I_NOP);
    chk("sat_taken", 64'(pred_taken), 1);
    upd(48'h1000, 48'h2400, 0);
    look(48'h1000, I_NOP);
    chk("sat_drop", 64'(pred_taken), 0);

    step(1, 48'h3000, I_NOP, 1, 48'h3000, 48'h3800, 1, 0);
    chk("nobypass_hit", 64'(pred_hit), 0);
    look(48'h3000, I_NOP);
    chk("after_upd_pc", 64'(pred_pc), 64'h3800);

    look(48'hFFFF_FFFF_FFFC, I_NOP);
    chk("pc_wrap", 64'(pred_pc), 0);

    do_reset();
    for (int k = 0; k <= ENT; k++) upd(48'h5000 + 48'(16*k), 48'h9000 + 48'(16*k), 1);
    look(48'h5000, I_NOP);
    chk("evict_first", 64'(pred_hit), 0);
    look(48'h5010, I_NOP);
    chk("keep_second", 64'(pred_hit), 1);
    upd(48'h7000, 48'h7100, 1);
    look(48'h5010, I_NOP);
    chk("rr_wrap1", 64'(pred_hit), 0);

    do_reset();
    look(48'h100, I_JAL_X1);
    look(48'h200, I_RET_X1);
`ifdef BP_RAS_EN
    chk("call_ret", 64'(pred_pc), 64'h104);
`else
    chk("call_ret", 64'(pred_pc), 64'h204);
`endif
    for (int k = 0; k <= RD; k++) look(48'h8000 + 48'(256*k), I_JAL_X1);
    for (int k = 0; k <= RD; k++) begin
      look(48'h9000 + 48'(16*k), I_RET_X1);
`ifdef BP_RAS_EN
      if (k == 0) chk("pop_newest", 64'(pred_pc), 64'h8000 + 64'(256*RD) + 64'h4);
`endif
    end
    chk("pop_empty_pc", 64'(pred_pc), 64'h9000 + 64'(16*RD) + 64'h4);
    look(48'hA000, I_JAL_X1);
    step(0, '0, I_NOP, 0, '0, '0, 0, 1);
    look(48'hB000, I_RET_X1);
    chk("flush_pop_pc", 64'(pred_pc), 64'hB004);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      rpc  = 48'h4000 + 48'(4 * $urandom_range(0, 23));
      rupc = 48'h4000 + 48'(4 * $urandom_range(0, 23));
      rtgt[47:32] = 16'($urandom);
      rtgt[31:0]  = $urandom;
      rtgt[1:0]   = 2'b00;
      step(($urandom % 4) != 0, rpc, ins_tab[$urandom_range(0, 6)],
           $urandom_range(0, 1) == 1, rupc, rtgt, $urandom_range(0, 1) == 1,
           ($urandom % 16) == 0);
    end

    upd(48'h6000, 48'h6100, 1);
    look(48'h6000, I_NOP);
    lk_valid = 1; lk_pc = 48'h6200; lk_instr = I_JAL_X1;
    up_valid = 1; up_pc = 48'h6300; up_target = 48'h6400; up_taken = 1;
    #2;
    reset = 1;
    #1;
    chk("midrst_valid", 64'(pred_valid), 0);
    chk("midrst_taken", 64'(pred_taken), 0);
    chk("midrst_pc", 64'(pred_pc), 0);
    model_clear();
    @(posedge clk); #1;
    reset = 0;
    look(48'h6000, I_RET_X1);
    chk("midrst_btb", 64'(pred_hit), 0);
    chk("midrst_ras", 64'(pred_pc), 64'h6004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
